// File: rtl/led_spi_receiver.sv
// SPI slave modelling a MAX7219-style LED controller: oversamples the serial
// bus, assembles 16-bit frames and commits them to a small register file.
module led_spi_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_LED_CLK,
  input  logic       in_MOSI,
  input  logic       in_CS,
  input  logic [2:0] in_RD_ADDR,
  output logic [7:0] out_RD_DATA,
  output logic       out_FRAME_VALID,
  output logic       out_FRAME_ERR,
  output logic [3:0] out_ADDR,
  output logic [7:0] out_DATA,
  output logic       out_DOUT,
  output logic [7:0] out_DECODE,
  output logic [3:0] out_INTENSITY,
  output logic [2:0] out_SCAN_LIMIT,
  output logic       out_SHUTDOWN,
  output logic       out_TEST
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] ledClkSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic                   ledClkPrev_q;
  logic                   csPrev_q;
  logic [3:0]             flushCnt_q;
  logic                   csArmed_q;

  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [4:0]             bitCount_q, bitCount_d;
  logic [3:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   regWrite;
  logic [15:0][7:0]       regs_q;

  logic                   ledClkRise;
  logic                   csRise;
  logic                   csFall;
  logic                   flushDone;
  logic [3:0]             rdIdx;
  logic [3:0]             frameAddr;

  assign flushDone  = (flushCnt_q >= 4'(SYNC_STAGES));
  assign ledClkRise = ledClkSync_q[LAST] & ~ledClkPrev_q;
  assign csRise     = csSync_q[LAST] & ~csPrev_q;
  assign csFall     = csArmed_q & csPrev_q & ~csSync_q[LAST];
  assign frameAddr  = shift_q[11:8];

  // Input synchronizers and edge history; CS history resets high and a low CS
  // seen straight out of reset is not allowed to count as a falling edge until
  // the chain has flushed and CS has actually been observed high.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      ledClkSync_q <= '0;
      mosiSync_q   <= '0;
      csSync_q     <= '1;
      ledClkPrev_q <= 1'b0;
      csPrev_q     <= 1'b1;
      flushCnt_q   <= '0;
      csArmed_q    <= 1'b0;
    end else begin
      ledClkSync_q <= {ledClkSync_q[SYNC_STAGES-2:0], in_LED_CLK};
      mosiSync_q   <= {mosiSync_q[SYNC_STAGES-2:0], in_MOSI};
      csSync_q     <= {csSync_q[SYNC_STAGES-2:0], in_CS};
      ledClkPrev_q <= ledClkSync_q[LAST];
      csPrev_q     <= csSync_q[LAST];
      if (!flushDone) begin
        flushCnt_q <= flushCnt_q + 4'd1;
      end
      if (flushDone && csSync_q[LAST]) begin
        csArmed_q <= 1'b1;
      end
    end
  end

  // Frame FSM: shift on synced clock edges, decide valid/error on CS release.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCount_d = bitCount_q;
    addr_d     = addr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    regWrite   = 1'b0;
    case (state_q)
      IDLE: begin
        if (csFall) begin
          state_d    = SHIFT;
          bitCount_d = '0;
        end
      end
      SHIFT: begin
        if (csRise) begin
          state_d = COMMIT;
          if (bitCount_q >= 5'(FRAME_BITS)) begin
            valid_d  = 1'b1;
            addr_d   = frameAddr;
            data_d   = shift_q[7:0];
            regWrite = (frameAddr != 4'h0) && (frameAddr != 4'hD) &&
                       (frameAddr != 4'hE);
          end else if (bitCount_q != 5'd0) begin
            err_d = 1'b1;
          end
        end else if (ledClkRise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosiSync_q[LAST]};
          if (bitCount_q != 5'd31) begin
            bitCount_d = bitCount_q + 5'd1;
          end
        end
      end
      COMMIT: begin
        if (csFall) begin
          state_d    = SHIFT;
          bitCount_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state and reporting registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCount_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCount_q <= bitCount_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Register file indexed by frame address; no-op/unused addresses never write.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      regs_q <= '0;
    end else if (regWrite) begin
      regs_q[addr_d] <= data_d;
    end
  end

  assign rdIdx           = {1'b0, in_RD_ADDR} + 4'd1;
  assign out_RD_DATA     = regs_q[rdIdx];
  assign out_FRAME_VALID = valid_q;
  assign out_FRAME_ERR   = err_q;
  assign out_ADDR        = addr_q;
  assign out_DATA        = data_q;
  assign out_DOUT        = shift_q[FRAME_BITS-1];
  assign out_DECODE      = regs_q[4'h9];
  assign out_INTENSITY   = regs_q[4'hA][3:0];
  assign out_SCAN_LIMIT  = regs_q[4'hB][2:0];
  assign out_SHUTDOWN    = ~regs_q[4'hC][0];
  assign out_TEST        = regs_q[4'hF][0];

endmodule

// File: tb/tb_led_spi_receiver.sv
// Self-checking bench for led_spi_receiver against a frame-level register model.
module tb_led_spi_receiver;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_LED_CLK;
  logic       in_MOSI;
  logic       in_CS;
  logic [2:0] in_RD_ADDR;
  logic [7:0] out_RD_DATA;
  logic       out_FRAME_VALID;
  logic       out_FRAME_ERR;
  logic [3:0] out_ADDR;
  logic [7:0] out_DATA;
  logic       out_DOUT;
  logic [7:0] out_DECODE;
  logic [3:0] out_INTENSITY;
  logic [2:0] out_SCAN_LIMIT;
  logic       out_SHUTDOWN;
  logic       out_TEST;

  int nChecks  = 0;
  int nFails   = 0;
  int validCnt = 0;
  int errCnt   = 0;
  int expValid = 0;
  int expErr   = 0;

  logic [7:0]  mRegs [16];
  logic [3:0]  mAddr;
  logic [7:0]  mData;
  logic [15:0] mShift;
  logic        doutLog [64];

  led_spi_receiver dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_LED_CLK(in_LED_CLK),
    .in_MOSI(in_MOSI),
    .in_CS(in_CS),
    .in_RD_ADDR(in_RD_ADDR),
    .out_RD_DATA(out_RD_DATA),
    .out_FRAME_VALID(out_FRAME_VALID),
    .out_FRAME_ERR(out_FRAME_ERR),
    .out_ADDR(out_ADDR),
    .out_DATA(out_DATA),
    .out_DOUT(out_DOUT),
    .out_DECODE(out_DECODE),
    .out_INTENSITY(out_INTENSITY),
    .out_SCAN_LIMIT(out_SCAN_LIMIT),
    .out_SHUTDOWN(out_SHUTDOWN),
    .out_TEST(out_TEST)
  );

  always #5 in_clk = ~in_clk;

  // Count every VALID/ERR pulse cycle, sampled away from the active edge.
  always @(negedge in_clk) begin
    if (out_FRAME_VALID === 1'b1) validCnt++;
    if (out_FRAME_ERR === 1'b1) errCnt++;
  end

  // Stop a hung run with a visible failure.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = 8'h00;
    mAddr  = 4'h0;
    mData  = 8'h00;
    mShift = 16'h0000;
  endtask

  task automatic modelFrame(input logic [63:0] bits, input int n);
    logic [3:0] a;
    for (int i = n - 1; i >= 0; i--) mShift = {mShift[14:0], bits[i]};
    if (n >= 16) begin
      a = mShift[11:8];
      mAddr = a;
      mData = mShift[7:0];
      expValid++;
      if (a != 4'h0 && a != 4'hD && a != 4'hE) mRegs[a] = mShift[7:0];
    end else if (n > 0) begin
      expErr++;
    end
  endtask

  task automatic shiftBits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      in_MOSI = bits[i];
      repeat (4) @(negedge in_clk);
      in_LED_CLK = 1'b1;
      repeat (4) @(negedge in_clk);
      in_LED_CLK = 1'b0;
      doutLog[n - 1 - i] = out_DOUT;
    end
  endtask

  task automatic sendFrame(input logic [63:0] bits, input int n, input int csHigh);
    @(negedge in_clk);
    in_CS = 1'b0;
    repeat (4) @(negedge in_clk);
    shiftBits(bits, n);
    repeat (4) @(negedge in_clk);
    in_CS = 1'b1;
    modelFrame(bits, n);
    repeat (csHigh) @(negedge in_clk);
  endtask

  task automatic test_reset();
    nChecks++; if (out_FRAME_VALID !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b expected 0", out_FRAME_VALID); end
    nChecks++; if (out_FRAME_ERR !== 1'b0) begin nFails++; $display("FAIL reset_err: got %b expected 0", out_FRAME_ERR); end
    nChecks++; if (out_ADDR !== 4'h0 || out_DATA !== 8'h00) begin nFails++; $display("FAIL reset_addr_data: got %h/%h expected 0/00", out_ADDR, out_DATA); end
    nChecks++; if (out_DOUT !== 1'b0) begin nFails++; $display("FAIL reset_dout: got %b expected 0", out_DOUT); end
    nChecks++; if (out_SHUTDOWN !== 1'b1) begin nFails++; $display("FAIL reset_shutdown: got %b expected 1", out_SHUTDOWN); end
    nChecks++; if ({out_DECODE, out_INTENSITY, out_SCAN_LIMIT, out_TEST} !== 16'h0000) begin nFails++; $display("FAIL reset_ctrl: got %h %h %h %b expected zeros", out_DECODE, out_INTENSITY, out_SCAN_LIMIT, out_TEST); end
    for (int a = 0; a < 8; a++) begin
      in_RD_ADDR = 3'(a);
      #1;
      nChecks++; if (out_RD_DATA !== 8'h00) begin nFails++; $display("FAIL reset_digit%0d: got %h expected 00", a, out_RD_DATA); end
    end
  endtask

  task automatic test_intensity_write();
    sendFrame(64'h0A05, 16, 0);
    @(negedge in_clk);
    nChecks++; if (out_FRAME_VALID !== 1'b0) begin nFails++; $display("FAIL latency_k: got %b expected 0", out_FRAME_VALID); end
    @(negedge in_clk);
    nChecks++; if (out_FRAME_VALID !== 1'b0) begin nFails++; $display("FAIL latency_k1: got %b expected 0", out_FRAME_VALID); end
    @(negedge in_clk);
    nChecks++; if (out_FRAME_VALID !== 1'b1) begin nFails++; $display("FAIL latency_k2: got %b expected 1", out_FRAME_VALID); end
    nChecks++; if (out_INTENSITY !== mRegs[10][3:0]) begin nFails++; $display("FAIL intensity_with_valid: got %h expected %h", out_INTENSITY, mRegs[10][3:0]); end
    @(negedge in_clk);
    nChecks++; if (out_FRAME_VALID !== 1'b0) begin nFails++; $display("FAIL valid_width: got %b expected 0", out_FRAME_VALID); end
    repeat (4) @(negedge in_clk);
    nChecks++; if (validCnt !== expValid) begin nFails++; $display("FAIL intensity_valid_count: got %0d expected %0d", validCnt, expValid); end
    nChecks++; if (out_ADDR !== mAddr || out_DATA !== mData) begin nFails++; $display("FAIL intensity_addr_data: got %h/%h expected %h/%h", out_ADDR, out_DATA, mAddr, mData); end
    nChecks++; if (out_INTENSITY !== 4'h5) begin nFails++; $display("FAIL intensity_value: got %h expected 5", out_INTENSITY); end
  endtask

  task automatic test_digit_fill();
    logic [7:0] rowAddr;
    sendFrame(64'h0C01, 16, 8);
    for (int i = 1; i <= 8; i++) begin
      rowAddr = 8'(i);
      sendFrame({48'h0, rowAddr, 8'h80 + rowAddr}, 16, 8);
    end
    repeat (4) @(negedge in_clk);
    nChecks++; if (out_SHUTDOWN !== ~mRegs[12][0]) begin nFails++; $display("FAIL fill_shutdown: got %b expected %b", out_SHUTDOWN, ~mRegs[12][0]); end
    nChecks++; if (validCnt !== expValid) begin nFails++; $display("FAIL fill_valid_count: got %0d expected %0d", validCnt, expValid); end
    for (int a = 0; a < 8; a++) begin
      in_RD_ADDR = 3'(a);
      #1;
      nChecks++; if (out_RD_DATA !== mRegs[a + 1]) begin nFails++; $display("FAIL fill_row%0d: got %h expected %h", a, out_RD_DATA, mRegs[a + 1]); end
    end
  endtask

  task automatic test_short_frame();
    sendFrame(64'(10'h2A5), 10, 8);
    repeat (4) @(negedge in_clk);
    nChecks++; if (errCnt !== expErr) begin nFails++; $display("FAIL short_err_count: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (validCnt !== expValid) begin nFails++; $display("FAIL short_valid_count: got %0d expected %0d", validCnt, expValid); end
    nChecks++; if (out_ADDR !== mAddr || out_DATA !== mData) begin nFails++; $display("FAIL short_addr_data: got %h/%h expected %h/%h", out_ADDR, out_DATA, mAddr, mData); end
    in_RD_ADDR = 3'd4;
    #1;
    nChecks++; if (out_RD_DATA !== mRegs[5]) begin nFails++; $display("FAIL short_row4: got %h expected %h", out_RD_DATA, mRegs[5]); end
    nChecks++; if (out_INTENSITY !== mRegs[10][3:0]) begin nFails++; $display("FAIL short_intensity: got %h expected %h", out_INTENSITY, mRegs[10][3:0]); end
  endtask

  task automatic test_daisy_chain();
    logic [15:0] upper;
    upper = 16'h0B07;
    sendFrame(64'h0B07_0A03, 32, 8);
    repeat (4) @(negedge in_clk);
    nChecks++; if (out_INTENSITY !== 4'h3) begin nFails++; $display("FAIL daisy_intensity: got %h expected 3", out_INTENSITY); end
    nChecks++; if (out_SCAN_LIMIT !== mRegs[11][2:0]) begin nFails++; $display("FAIL daisy_scan_limit: got %h expected %h", out_SCAN_LIMIT, mRegs[11][2:0]); end
    nChecks++; if (out_ADDR !== 4'hA || out_DATA !== 8'h03) begin nFails++; $display("FAIL daisy_addr_data: got %h/%h expected A/03", out_ADDR, out_DATA); end
    for (int j = 0; j < 16; j++) begin
      nChecks++; if (doutLog[15 + j] !== upper[15 - j]) begin nFails++; $display("FAIL daisy_dout%0d: got %b expected %b", j, doutLog[15 + j], upper[15 - j]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int validBase;
    int errBase;
    errBase = errCnt;
    @(negedge in_clk);
    in_CS = 1'b0;
    repeat (4) @(negedge in_clk);
    shiftBits(64'h09, 8);
    in_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    in_rst = 1'b0;
    modelReset();
    validBase = validCnt;
    repeat (6) @(negedge in_clk);
    in_CS = 1'b1;
    repeat (6) @(negedge in_clk);
    nChecks++; if (validCnt !== validBase) begin nFails++; $display("FAIL midreset_no_valid: got %0d expected %0d", validCnt, validBase); end
    sendFrame(64'h0A0F, 16, 8);
    repeat (4) @(negedge in_clk);
    nChecks++; if (validCnt - validBase !== 1) begin nFails++; $display("FAIL midreset_one_valid: got %0d expected 1", validCnt - validBase); end
    nChecks++; if (errCnt !== errBase) begin nFails++; $display("FAIL midreset_err: got %0d expected %0d", errCnt, errBase); end
    nChecks++; if (out_DECODE !== 8'h00) begin nFails++; $display("FAIL midreset_decode: got %h expected 00", out_DECODE); end
    nChecks++; if (out_INTENSITY !== 4'hF) begin nFails++; $display("FAIL midreset_intensity: got %h expected f", out_INTENSITY); end
    expValid = validCnt;
    expErr   = errCnt;
  endtask

  task automatic test_back_to_back();
    int validBase;
    validBase = validCnt;
    sendFrame(64'h0B05, 16, 1);
    sendFrame(64'h0F01, 16, 8);
    repeat (4) @(negedge in_clk);
    nChecks++; if (validCnt - validBase !== 2) begin nFails++; $display("FAIL b2b_valid_count: got %0d expected 2", validCnt - validBase); end
    nChecks++; if (out_SCAN_LIMIT !== 3'd5) begin nFails++; $display("FAIL b2b_scan_limit: got %h expected 5", out_SCAN_LIMIT); end
    nChecks++; if (out_TEST !== 1'b1) begin nFails++; $display("FAIL b2b_test: got %b expected 1", out_TEST); end
  endtask

  task automatic test_random();
    logic [63:0] bits;
    int n;
    for (int it = 0; it < 14; it++) begin
      bits = {$urandom, $urandom};
      n = $urandom_range(0, 24);
      sendFrame(bits, n, $urandom_range(2, 6));
      repeat (4) @(negedge in_clk);
      in_RD_ADDR = 3'($urandom_range(0, 7));
      #1;
      nChecks++; if (validCnt !== expValid || errCnt !== expErr) begin nFails++; $display("FAIL rand%0d_pulses: got %0d/%0d expected %0d/%0d", it, validCnt, errCnt, expValid, expErr); end
      nChecks++; if (out_ADDR !== mAddr || out_DATA !== mData) begin nFails++; $display("FAIL rand%0d_addr_data: got %h/%h expected %h/%h", it, out_ADDR, out_DATA, mAddr, mData); end
      nChecks++; if (out_RD_DATA !== mRegs[in_RD_ADDR + 4'd1]) begin nFails++; $display("FAIL rand%0d_rd: got %h expected %h", it, out_RD_DATA, mRegs[in_RD_ADDR + 4'd1]); end
      nChecks++; if ({out_DECODE, out_INTENSITY, out_SCAN_LIMIT, out_SHUTDOWN, out_TEST} !== {mRegs[9], mRegs[10][3:0], mRegs[11][2:0], ~mRegs[12][0], mRegs[15][0]}) begin
        nFails++; $display("FAIL rand%0d_ctrl: got %h %h %h %b %b expected %h %h %h %b %b", it, out_DECODE, out_INTENSITY, out_SCAN_LIMIT, out_SHUTDOWN, out_TEST, mRegs[9], mRegs[10][3:0], mRegs[11][2:0], ~mRegs[12][0], mRegs[15][0]);
      end
      nChecks++; if (out_DOUT !== mShift[15]) begin nFails++; $display("FAIL rand%0d_dout: got %b expected %b", it, out_DOUT, mShift[15]); end
    end
  endtask

  initial begin
    in_rst     = 1'b1;
    in_LED_CLK = 1'b0;
    in_MOSI    = 1'b0;
    in_CS      = 1'b1;
    in_RD_ADDR = 3'd0;
    modelReset();
    repeat (4) @(negedge in_clk);
    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);
    $display("[TB] starting");
    test_reset();
    test_intensity_write();
    test_digit_fill();
    test_short_frame();
    test_daisy_chain();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/led_spi_receiver.md
# led_spi_receiver

Receive-side counterpart of `led_driver`. It sits on the `out_LED_CLK`/`out_MOSI`/`out_CS` bus as an SPI slave that models a MAX7219-style LED matrix controller. It oversamples the serial lines in the system clock domain, assembles 16-bit frames, commits them to an internal register file and exposes display state for the LED model and the self-checking benches. It also provides a daisy-chain serial output.

## Interface
- `FRAME_BITS`, 16: bits per frame, MSB first.
- `SYNC_STAGES`, 2: flip-flop synchronizer depth on each serial input.
- `in_clk` input 1: system clock; must be ≥4× the LED_CLK frequency.
- `in_rst` input 1: synchronous, active-high reset.
- `in_LED_CLK` input 1: serial clock; data is sampled on its rising edge.
- `in_MOSI` input 1: serial data.
- `in_CS` input 1: active-low frame select.
- `in_RD_ADDR` input 3: digit row select for read-back.
- `out_RD_DATA` output 8: digit register `in_RD_ADDR`+1, combinational read.
- `out_FRAME_VALID` output 1: one-cycle pulse when a frame is accepted.
- `out_FRAME_ERR` output 1: one-cycle pulse when a short frame is rejected.
- `out_ADDR` output 4: address of the last accepted frame.
- `out_DATA` output 8: data of the last accepted frame.
- `out_DOUT` output 1: shift-register MSB, used for daisy-chaining.
- `out_DECODE` output 8: register 0x9.
- `out_INTENSITY` output 4: register 0xA[3:0].
- `out_SCAN_LIMIT` output 3: register 0xB[2:0].
- `out_SHUTDOWN` output 1: inverse of register 0xC[0] (1 = shut down).
- `out_TEST` output 1: register 0xF[0].

## Operation
- **Synchronizers.** `in_LED_CLK`, `in_MOSI` and `in_CS` each pass through `SYNC_STAGES` flops. Edge detection compares the last synchronizer stage with its one-cycle-delayed copy.
- **States.**
  - IDLE: synced CS is high.
  - SHIFT: entered on a synced CS falling edge. Entry clears the bit counter; the shift register keeps its contents.
  - COMMIT: entered on a synced CS rising edge. Lasts one cycle, then returns to IDLE.
- **SHIFT.** On each synced LED_CLK rising edge: `shift <= {shift[FRAME_BITS-2:0], MOSI_sync}`. The bit counter increments and saturates at 31.
- **Outside SHIFT.** LED_CLK edges are ignored.
- **Frame layout.** Bits [15:12] are don't-care, [11:8] are the address, [7:0] are the data.
- **COMMIT decision.**
  - Count ≥ 16: frame valid. The last 16 bits shifted in are the frame (daisy-chain semantics). Pulse `out_FRAME_VALID` and update `out_ADDR`/`out_DATA`.
  - Count 1–15: pulse `out_FRAME_ERR`. No register or `out_ADDR`/`out_DATA` update.
  - Count 0: no pulse, no update.
- **Register writes on a valid frame.**
  - Address 0x1–0x8: digit rows 0–7.
  - Address 0x9, 0xA, 0xB, 0xC, 0xF: control registers.
  - Address 0x0 (no-op), 0xD, 0xE: frame still reported valid; no register written.
- **Reserved bits.** Only the listed bits of 0xA/0xB/0xC/0xF drive outputs. All 8 bits are stored.
- **`out_DOUT`.** Equals `shift[15]` at all times, so it trails `in_MOSI` by 16 LED_CLK edges plus synchronizer latency.
- **Reset.** A reset mid-frame discards the partial frame and returns to IDLE. A CS low that is still present when reset releases is not treated as a falling edge: the synchronizer history resets to "high", so a new falling edge is required.

## Timing
- **Reset values.**
  - Registers 0x1–0xB, 0xF: 0x00.
  - Register 0xC: 0x00, so `out_SHUTDOWN` = 1.
  - Shift register 0, bit counter 0, state IDLE.
  - `out_FRAME_VALID`, `out_FRAME_ERR`, `out_ADDR`, `out_DATA`, `out_DOUT`: all 0.
- **Latency.** The raw CS rise is first sampled at edge k. Register updates, `out_ADDR`/`out_DATA` and the VALID/ERR pulse are all visible after edge k+SYNC_STAGES (3 edges total at the default).
- **Read-back.** `out_RD_DATA` reflects the new value in the same cycle `out_FRAME_VALID` is high.
- **Minimum timing.**
  - CS high time between frames: 2 in_clk cycles.
  - LED_CLK high and low times: 2 in_clk cycles each.
  - Violations are undefined.
- **Simultaneous events.** A CS rising edge and an LED_CLK rising edge in the same synced cycle: the clock edge is dropped and CS wins. This matches the driver, which never clocks at the CS release.
- **Back-to-back frames.** One COMMIT cycle is the only dead time. A CS falling edge during COMMIT is honoured on the next cycle.

## Test plan
- **Intensity write.** Reset; send 0x0A05 with LED_CLK = clk/8 → `out_FRAME_VALID` pulses once, `out_ADDR`=0xA, `out_DATA`=0x05, `out_INTENSITY`=5.
- **Digit fill and read-back.** Send 0x0C01, then 0x0181 … 0x0888 → `out_SHUTDOWN`=0; `in_RD_ADDR`=0..7 returns 0x81..0x88.
- **Short frame.** Send 10 bits, then raise CS → `out_FRAME_ERR` pulses; `out_ADDR`/`out_DATA` and all registers unchanged.
- **Daisy chain.** Send a 32-bit frame 0x0B07_0A03 → only 0x0A03 is committed (`out_INTENSITY`=3, `out_SCAN_LIMIT` unchanged at 0). `out_DOUT` reproduces 0x0B07 delayed by 16 clocks.
- **Reset mid-frame.** Assert `in_rst` after 8 bits of 0x0955, then send 0x0A0F → `out_DECODE`=0x00, `out_INTENSITY`=0xF, exactly one VALID pulse after reset.
- **End-to-end with `led_driver`.** Connect to `led_driver`, pulse `in_IR_START` for 2 cycles → every frame sent yields a VALID pulse with zero ERR pulses; the register contents match the driver's init sequence.
